// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep-and-capture stage.
// Defines the FSM state encoding, row geometry and settle counter width.
// Helper maps a row index onto its bit position in the captured rule word.
package tt_sweep_pkg;

  localparam int ROWS  = 8;
  localparam int ROW_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Row k lands in bit 7-k so the word reads in Wolfram/Cello hex order.
  function automatic logic [ROW_W-1:0] tt_bit_idx(input logic [ROW_W-1:0] row);
    return ROW_W'(ROWS - 1) - row;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter timing how long each input row is held before sampling.
// Latency: expire is high in the cycle where the count reaches 1, i.e. load_val cycles after load.
// No backpressure: load has priority, otherwise the count decrements until it rests at zero.
module tt_settle_timer
  import tt_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on request, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps a 3-input gate through rows 000..111, samples its output per row and assembles the rule word.
// Latency: done/tt_valid rise 8*(SETTLE+1)+1 cycles after start; 8*(SETTLE+2)+1 with TT_SWEEP_STABLE_CHECK_EN.
// Build option TT_SWEEP_STABLE_CHECK_EN: two samples per row, disagreement flagged in unstable. start ignored unless IDLE.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE   = 4,
  parameter logic [7:0]  EXPECTED = 8'h5C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_word,
  output logic       tt_valid,
  output logic       tt_match,
  output logic [7:0] unstable
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             accept_q, accept_d;
  logic [7:0]       word_q, word_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timer_load;
  logic             timer_expire;
  logic             row_end;
  logic [ROW_W-1:0] bit_idx;

`ifdef TT_SWEEP_STABLE_CHECK_EN
  logic       phase_q, phase_d;
  logic       first_q, first_d;
  logic [7:0] unstable_q, unstable_d;

  // A row finishes on the second of its two sample cycles.
  assign row_end  = phase_q;
  assign unstable = unstable_q;
`else
  assign row_end  = 1'b1;
  assign unstable = 8'h00;
`endif

  assign bit_idx = tt_bit_idx(row_q);

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (CNT_W'(SETTLE)),
    .expire   (timer_expire)
  );

  // Next-state and datapath: an accepted start is registered for one cycle, then row 0 is driven.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    word_d     = word_q;
    valid_d    = valid_q;
    timer_load = 1'b0;
    accept_d   = start && (state_q == IDLE) && !accept_q;
`ifdef TT_SWEEP_STABLE_CHECK_EN
    phase_d    = phase_q;
    first_d    = first_q;
    unstable_d = unstable_q;
    if (accept_d) begin
      unstable_d = 8'h00;
    end
`endif
    if (accept_d) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept_q) begin
          state_d    = DRIVE;
          row_d      = '0;
          timer_load = 1'b1;
        end
      end
      DRIVE: begin
        if (timer_expire) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
`ifdef TT_SWEEP_STABLE_CHECK_EN
        phase_d = ~phase_q;
        if (!phase_q) begin
          first_d = gate_out;
        end else begin
          unstable_d[bit_idx] = first_q ^ gate_out;
        end
`endif
        if (row_end) begin
          word_d[bit_idx] = gate_out;
          if (row_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            row_d      = row_q + ROW_W'(1);
            state_d    = DRIVE;
            timer_load = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == DONE) begin
      valid_d = 1'b1;
    end
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      accept_q   <= 1'b0;
      word_q     <= 8'h00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef TT_SWEEP_STABLE_CHECK_EN
      phase_q    <= 1'b0;
      first_q    <= 1'b0;
      unstable_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      accept_q   <= accept_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef TT_SWEEP_STABLE_CHECK_EN
      phase_q    <= phase_d;
      first_q    <= first_d;
      unstable_q <= unstable_d;
`endif
    end
  end

  assign {in1, in2, in3} = row_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign tt_word         = word_q;
  assign tt_valid        = valid_q;
  assign tt_match        = (word_q == EXPECTED);

endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Truth-table sweep-and-capture stage wrapped around a 3-input combinational logic gate such as a Wolfram-rule module. On a start pulse it drives `in1`, `in2` and `in3` through all eight input combinations. After a settle interval it samples the gate's 1-bit `out` and assembles the 8-bit rule word, for example 0x5C. It flags whether the captured word matches an expected value. It sits directly upstream (driving the inputs) and downstream (consuming the output) of the gate under characterization.

## Interface
- `SETTLE`, default 4: cycles each input combination is held before sampling; legal range 1..255.
- `EXPECTED`, default 8'h5C: reference rule word compared against the capture.
- `clk` in 1: the only clock; every register is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a sweep.
- `gate_out` in 1: the gate's `out`.
- `in1`, `in2`, `in3` out 1 each: registered drive to the gate inputs.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse when a sweep completes.
- `tt_word` out 8: captured rule word.
- `tt_valid` out 1: `tt_word` is complete and current.
- `tt_match` out 1: equals `tt_word == EXPECTED`; meaningful only while `tt_valid` is high.
- `unstable` out 8: per-row sample-disagreement flags (see Configuration).

## Operation
- States:
  - IDLE → DRIVE on `start`.
  - DRIVE → SAMPLE after `SETTLE` cycles.
  - SAMPLE → DRIVE for the next row, or → DONE after row 7.
  - DONE → IDLE unconditionally.
- Row index k runs 0..7 with {in1,in2,in3} = k, so in1 is the MSB.
- Captured bit mapping: `tt_word[7-k]` = `gate_out` sampled for row k. This yields Wolfram/Cello hex notation.
- `start` is ignored in every state except IDLE.
- Accepting `start` clears `tt_valid` and `unstable`. `tt_word` bits are overwritten row by row.
- `tt_valid` is set in DONE and holds until the next accepted `start` or reset.
- `busy` is high in DRIVE, SAMPLE and DONE.
- In IDLE the inputs hold the last row driven (3'b111 after a sweep).
- The settle counter is 8 bits and reloads at the entry to each row.
- Reset values:
  - `in1`, `in2`, `in3` = 0
  - `tt_word` = 8'h00
  - `unstable` = 8'h00
  - `tt_valid`, `busy`, `done` = 0
  - state = IDLE
- Reset mid-sweep returns to IDLE immediately. No partial result is flagged valid.

## Timing
- `start` is sampled high at edge 0. At edge 1 the block enters DRIVE, the inputs become 000 and `busy` goes to 1.
- Each row lasts `SETTLE` DRIVE cycles plus 1 SAMPLE cycle (plus 1 more with the stability check). `gate_out` is sampled at the edge ending SAMPLE.
- The input change to the next row occurs on that same edge.
- `done` and `tt_valid` rise 8·(SETTLE+1)+1 cycles after `start` (8·(SETTLE+2)+1 with the check).
- `done` is high for exactly one cycle. `busy` falls on the edge after `done`.
- A `start` asserted in the DONE cycle is ignored.
- A `start` asserted on the first IDLE cycle after DONE is accepted (back-to-back sweeps).

## Configuration
- Macro: `TT_SWEEP_STABLE_CHECK_EN`.
- When defined:
  - SAMPLE lasts 2 cycles, and `gate_out` is sampled on both.
  - The second sample is stored in `tt_word`.
  - `unstable[7-k]` is set if the two samples differ.
- When undefined:
  - Single sample per row.
  - `unstable` is tied to 8'h00.
  - No second-sample register is present.

## Structure
- Package `tt_sweep_pkg`:
  - state enum (IDLE, DRIVE, SAMPLE, DONE)
  - `ROWS` = 8
  - `ROW_W` = 3
  - settle counter width = 8
- Sub-module `tt_settle_timer`: a loadable down-counter with a `load`/`expire` interface, instantiated once by the FSM.

## Test plan
- Gate = rule 0x5C, `SETTLE`=4, one `start` → `tt_word`=8'h5C, `tt_match`=1, `done` rises 41 cycles after `start`.
- Gate = constant 0 with `EXPECTED`=8'h5C → `tt_word`=8'h00, `tt_match`=0, `tt_valid`=1.
- `start` pulsed repeatedly during a sweep → exactly one `done`; timing identical to a single `start`.
- Assert `rst` during row 3 → all outputs return to their reset values; a subsequent `start` produces a correct full sweep.
- With the macro defined, make `gate_out` toggle every cycle during row 2 only → `unstable`=8'b0010_0000; `done` rises 49 cycles after `start` for `SETTLE`=4.
- Back-to-back: `start` in the DONE cycle is ignored; `start` on the next IDLE cycle is accepted; `tt_valid` drops at that accepted `start`.
